seg7_display_arbiter: RTL and testbench
=======================================

SEG7_DISPLAY_ARBITER -- requirements
Module: seg7_display_arbiter

Interface
REQ-001 Parameter DIV_MAX, default 2000: scan tick period in clk cycles; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0  input  1  requester 0 wants the display.
REQ-005 data0  input  16  requester 0 BCD frame; [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-006 req1  input  1  requester 1 wants the display.
REQ-007 data1  input  16  requester 1 BCD frame; same nibble layout as data0.
REQ-008 gnt0  output  1  requester 0 owns the display.
REQ-009 gnt1  output  1  requester 1 owns the display.
REQ-010 digit  output  4  nibble of the active digit, to the 7-segment decoder.
REQ-011 an  output  4  anode enables, active-low, at most one bit low.

Function
REQ-012 Divider counts 0..DIV_MAX-1 and wraps; tick is the cycle where divider equals DIV_MAX-1.
REQ-013 Scan index idx (2 bits) increments on tick and wraps 3->0.
REQ-014 an = all ones except bit idx low; digit = frame nibble idx; both registered-state combinational, no extra latency.
REQ-015 Frame boundary (fb) is the cycle where tick is high and idx==3.
REQ-016 FSM states: IDLE, OWN0, OWN1; state, grants and frame change only on fb.
REQ-017 gnt0 high exactly in OWN0, gnt1 high exactly in OWN1; never both high.
REQ-018 On fb, next owner: current owner keeps the display if its req is high; otherwise the other requester if its req is high; otherwise IDLE.
REQ-019 On fb with both req high and no current owner, grant goes to the requester not in register last; last updates to each new owner.
REQ-020 No preemption: an owner holding req high is never displaced.
REQ-021 On fb, frame loads data of the next owner (OWN0: data0, OWN1: data1); in IDLE, frame holds its value and scanning continues.
REQ-022 Latency: req sampled on fb -> grant and new frame visible the cycle after fb; worst case 4*DIV_MAX cycles from req rise.
REQ-023 Requests that pulse and fall between boundaries are ignored.
REQ-024 Nibble values 10..15 pass to digit unmodified.

Reset
REQ-025 rst high: divider=0, idx=0, state=IDLE, gnt0=gnt1=0, frame=16'h0000, last=1; hence an=4'b1110, digit=4'h0.
REQ-026 rst mid-frame aborts ownership immediately; after release, arbitration restarts at the first fb, with requester 0 favoured by last=1.

Configuration
REQ-027 Macro SEG7_LZ_BLANK_EN, when defined: a digit position above the most significant nonzero nibble has its an bit forced high (blanked); the ones digit is never blanked; frame 0000 shows only ones.
REQ-028 SEG7_LZ_BLANK_EN undefined: all four positions light in turn; no blanking logic present.

Verification (bench uses DIV_MAX=4)
REQ-029 Reset, then 20 cycles with no req -> gnt0=gnt1=0; an sequence 1110,1101,1011,0111 every 4 cycles; digit=0.
REQ-030 req0=1, data0=16'h1234 -> gnt0 rises the cycle after the first fb; an=1110 shows 4, 1101 shows 3, 1011 shows 2, 0111 shows 1.
REQ-031 req0 and req1 rise together after reset -> OWN0; drop req0 -> OWN1 at the next fb; raise req0 while req1 held -> stays OWN1.
REQ-032 Owner drops req with the other idle -> IDLE at fb; frame holds last data; scanning continues.
REQ-033 Assert rst mid-frame while in OWN1 -> outputs take reset values immediately, without waiting for clk.
REQ-034 With SEG7_LZ_BLANK_EN defined, data0=16'h0042 -> an 1011 and 0111 never low; 4 and 2 shown; data0=16'h0000 -> only an=1110 low.

Source files
------------

// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter
//   Shares one multiplexed 4-digit 7-segment display between two requesters.
//   A free-running divider paces the digit scan. Ownership is re-arbitrated
//   only at frame boundaries (last digit of the scan), so a requester always
//   sees whole frames and an owner that keeps requesting is never displaced.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   req0   in   requester 0 wants the display
//   data0  in   requester 0 BCD frame {thousands, hundreds, tens, ones}
//   req1   in   requester 1 wants the display
//   data1  in   requester 1 BCD frame, same layout
//   gnt0   out  requester 0 owns the display
//   gnt1   out  requester 1 owns the display
//   digit  out  nibble of the active digit
//   an     out  active-low anode enables, at most one low
//
// Parameter
//   DIV_MAX  scan tick period in clk cycles (2..65535)
//
// Build option
//   SEG7_LZ_BLANK_EN  when defined, leading-zero digits are blanked
//                     (the ones digit always lights).
//
// State  | meaning
// -------+-----------------------------------------
// IDLE   | nobody owns the display, frame held
// OWN0   | requester 0 owns the display
// OWN1   | requester 1 owns the display

module seg7_display_arbiter #(
  parameter int DIV_MAX = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [3:0]  digit,
  output logic [3:0]  an
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] div_cnt;
  logic [1:0]  idx;
  logic [15:0] frame;
  logic        last_own;   // 1: requester 1 was the most recent owner
  logic        tick;
  logic        fb;

  assign tick = (div_cnt == 16'(DIV_MAX - 1));
  assign fb   = tick && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= 16'd0;
      idx     <= 2'd0;
    end else begin
      if (tick) begin
        div_cnt <= 16'd0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  // Owner keeps the display while requesting; otherwise hand over; from IDLE
  // with both requesting, favour the one that did not own it last.
  always_comb begin
    state_nxt = state;
    case (state)
      OWN0: begin
        if (req0)      state_nxt = OWN0;
        else if (req1) state_nxt = OWN1;
        else           state_nxt = IDLE;
      end
      OWN1: begin
        if (req1)      state_nxt = OWN1;
        else if (req0) state_nxt = OWN0;
        else           state_nxt = IDLE;
      end
      default: begin
        if (req0 && req1) state_nxt = last_own ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
        else              state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      frame    <= 16'h0000;
      last_own <= 1'b1;
    end else if (fb) begin
      state <= state_nxt;
      case (state_nxt)
        OWN0: begin
          frame    <= data0;
          last_own <= 1'b0;
        end
        OWN1: begin
          frame    <= data1;
          last_own <= 1'b1;
        end
        default: frame <= frame;
      endcase
    end
  end

  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);

  always_comb begin
    digit = frame[3:0];
    case (idx)
      2'd0:    digit = frame[3:0];
      2'd1:    digit = frame[7:4];
      2'd2:    digit = frame[11:8];
      default: digit = frame[15:12];
    endcase
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [1:0] msd;   // position of the most significant nonzero nibble

  always_comb begin
    msd = 2'd0;
    if (frame[15:12] != 4'h0)     msd = 2'd3;
    else if (frame[11:8] != 4'h0) msd = 2'd2;
    else if (frame[7:4] != 4'h0)  msd = 2'd1;
  end

  always_comb begin
    an = 4'b1111;
    if (idx <= msd) an = ~(4'b0001 << idx);
  end
`else
  always_comb begin
    an = ~(4'b0001 << idx);
  end
`endif

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// tb_seg7_display_arbiter
//   Frame-level vector table plus hand-written sequences for request pulses,
//   handover and asynchronous reset. DIV_MAX=4, so one frame is 16 cycles.

module tb_seg7_display_arbiter;

  localparam int DIV = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] data0, data1;
  logic        gnt0, gnt1;
  logic [3:0]  digit, an;

  seg7_display_arbiter #(.DIV_MAX(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .data0 (data0),
    .req1  (req1),
    .data1 (data1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .digit (digit),
    .an    (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        g0;
    logic        g1;
    logic [3:0]  an;
    logic [3:0]  digit;
  } exp_t;

  typedef struct {
    logic        r0;
    logic        r1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        eg0;
    logic        eg1;
    logic [15:0] ef;
  } vec_t;

  exp_t sb[$];
  vec_t vt[12];
  int   n_vec = 0;
  int   n_miss = 0;

  function automatic logic [3:0] exp_an(input int pos, input logic [15:0] f);
    logic [3:0] a;
    a = 4'b1111;
    a[pos] = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    begin
      int top;
      top = 0;
      for (int k = 0; k < 4; k++) if (f[k*4 +: 4] != 4'h0) top = k;
      if (pos > top) a = 4'b1111;
    end
`endif
    return a;
  endfunction

  task automatic push_frame(input logic g0, input logic g1, input logic [15:0] f);
    exp_t e;
    for (int j = 0; j < FRAME; j++) begin
      e.g0    = g0;
      e.g1    = g1;
      e.an    = exp_an(j / DIV, f);
      e.digit = f[(j / DIV) * 4 +: 4];
      sb.push_back(e);
    end
  endtask

  task automatic pop_check(input int cyc);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL sb_empty cyc %0d: no expectation queued", cyc);
    end else begin
      e = sb.pop_front();
      if (gnt0 !== e.g0 || gnt1 !== e.g1 || an !== e.an || digit !== e.digit) begin
        n_miss++;
        $display("FAIL table cyc %0d: got g0=%b g1=%b an=%b digit=%h, want g0=%b g1=%b an=%b digit=%h",
                 cyc, gnt0, gnt1, an, digit, e.g0, e.g1, e.an, e.digit);
      end
    end
  endtask

  task automatic check(input string name, input logic g0, input logic g1,
                       input logic [3:0] a, input logic [3:0] d);
    n_vec++;
    if (gnt0 !== g0 || gnt1 !== g1 || an !== a || digit !== d) begin
      n_miss++;
      $display("FAIL %s: got g0=%b g1=%b an=%b digit=%h, want g0=%b g1=%b an=%b digit=%h",
               name, gnt0, gnt1, an, digit, g0, g1, a, d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    //          r0    r1    data0     data1     g0    g1    frame
    vt[0]  = '{1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vt[1]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1234};
    vt[2]  = '{1'b1, 1'b1, 16'h5678, 16'h9ABC, 1'b1, 1'b0, 16'h5678};
    vt[3]  = '{1'b0, 1'b1, 16'h5678, 16'h9ABC, 1'b0, 1'b1, 16'h9ABC};
    vt[4]  = '{1'b1, 1'b1, 16'h1111, 16'hDEF0, 1'b0, 1'b1, 16'hDEF0};
    vt[5]  = '{1'b0, 1'b0, 16'h2222, 16'h7777, 1'b0, 1'b0, 16'hDEF0};
    vt[6]  = '{1'b1, 1'b1, 16'h0042, 16'h0300, 1'b1, 1'b0, 16'h0042};
    vt[7]  = '{1'b0, 1'b0, 16'h0999, 16'h0999, 1'b0, 1'b0, 16'h0042};
    vt[8]  = '{1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0000};
    vt[9]  = '{1'b0, 1'b1, 16'h0000, 16'h0500, 1'b0, 1'b1, 16'h0500};
    vt[10] = '{1'b1, 1'b0, 16'h8009, 16'h0000, 1'b1, 1'b0, 16'h8009};
    vt[11] = '{1'b0, 1'b0, 16'h1357, 16'h2468, 1'b0, 1'b0, 16'h8009};

    req0 = 1'b0; req1 = 1'b0; data0 = 16'h0; data1 = 16'h0;
    do_reset();

    // Table: inputs held for a whole frame, result visible in the next one.
    cyc = 0;
    push_frame(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      req0 = vt[i].r0; req1 = vt[i].r1; data0 = vt[i].d0; data1 = vt[i].d1;
      push_frame(vt[i].eg0, vt[i].eg1, vt[i].ef);
      for (int j = 0; j < FRAME; j++) begin
        @(negedge clk);
        pop_check(cyc);
        cyc++;
      end
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      pop_check(cyc);
      cyc++;
    end

    // Short request pulse between boundaries is ignored.
    do_reset();
    check("rst_vals", 1'b0, 1'b0, 4'b1110, 4'h0);
    repeat (4) @(posedge clk); #1 req1 = 1'b1;
    repeat (2) @(posedge clk); #1 req1 = 1'b0;
    repeat (FRAME - 6) @(posedge clk); #1;
    check("pulse_ignored", 1'b0, 1'b0, 4'b1110, 4'h0);

    // Both rise together after reset: last=1 favours requester 0.
    req0 = 1'b1; req1 = 1'b1; data0 = 16'h2468; data1 = 16'h1357;
    repeat (FRAME - 1) @(posedge clk); #1;
    check("no_early_grant", 1'b0, 1'b0, 4'b0111, 4'h0);
    @(posedge clk); #1;
    check("both_own0", 1'b1, 1'b0, 4'b1110, 4'h8);

    req0 = 1'b0;
    repeat (FRAME) @(posedge clk); #1;
    check("drop_own1", 1'b0, 1'b1, 4'b1110, 4'h7);

    req0 = 1'b1;
    repeat (FRAME) @(posedge clk); #1;
    check("no_preempt", 1'b0, 1'b1, 4'b1110, 4'h7);

    // Asynchronous reset in the middle of a frame while in OWN1.
    repeat (5) @(posedge clk); #1;
    check("own1_mid", 1'b0, 1'b1, 4'b1101, 4'h5);
    #2 rst = 1'b1;
    #1 check("async_rst", 1'b0, 1'b0, 4'b1110, 4'h0);
    @(posedge clk); #1;
    check("rst_held", 1'b0, 1'b0, 4'b1110, 4'h0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
